uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: one-hot receiver states, stop-bit encoding, clog2
package uart_pkg;

    localparam int DEFAULT_NUM_TICKS = 16;

    localparam logic [1:0] STOP_TWO = 2'd2;

    localparam logic [4:0] ST_IDLE   = 5'b00001;
    localparam logic [4:0] ST_START  = 5'b00010;
    localparam logic [4:0] ST_DATA   = 5'b00100;
    localparam logic [4:0] ST_PARITY = 5'b01000;
    localparam logic [4:0] ST_STOP   = 5'b10000;

    typedef enum logic [4:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } rx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchroniser for rx_in with falling-edge detect
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_sync,
    output logic fall_pulse
);

    logic meta;
    logic prev;

    // Flops reset to 1 so that a released reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta    <= 1'b1;
            rx_sync <= 1'b1;
            prev    <= 1'b1;
        end else begin
            meta    <= rx_in;
            rx_sync <= meta;
            prev    <= rx_sync;
        end
    end

    assign fall_pulse = prev & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N/8E with 1 or 2 stop bits; UART_RX_MAJORITY_VOTE_EN enables 2-of-3 bit voting
module uart_rx
    import uart_pkg::*;
#(
    parameter int NUM_TICKS     = DEFAULT_NUM_TICKS,
    parameter int BITS_PER_DATA = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     rx_in,
    input  logic                     parity,
    input  logic [1:0]               stop_bits,
    output logic [BITS_PER_DATA-1:0] d_out,
    output logic                     rx_done,
    output logic                     parity_err,
    output logic                     frame_err
);

    localparam int SW = clog2(NUM_TICKS);
    localparam int NW = clog2(BITS_PER_DATA);
    localparam logic [SW-1:0] SP     = SW'(NUM_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(NUM_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(BITS_PER_DATA - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [SW-1:0] DP = SP + 1'b1;
`else
    localparam logic [SW-1:0] DP = SP;
`endif

    rx_state_t state;
    rx_state_t state_next;

    logic                     rx_sync;
    logic                     fall_pulse;
    logic                     sample_bit;
    logic [SW-1:0]            s;
    logic [NW-1:0]            n;
    logic [BITS_PER_DATA-1:0] sr;
    logic                     cfg_parity;
    logic                     cfg_two;
    logic                     par_bit;
    logic                     ferr_pend;
    logic                     stop_idx;

    logic start_frame;
    logic s_clr;
    logic s_inc;
    logic n_clr;
    logic n_inc;
    logic shift_en;
    logic par_store;
    logic stop_chk;
    logic stop_adv;
    logic finish;

    uart_rx_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .rx_sync    (rx_sync),
        .fall_pulse (fall_pulse)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist holds the samples from the two previous ticks (SP-1, SP) when s reaches SP+1.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rx_sync};
        end
    end

    assign sample_bit = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
    assign sample_bit = rx_sync;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        s_clr       = 1'b0;
        s_inc       = 1'b0;
        n_clr       = 1'b0;
        n_inc       = 1'b0;
        shift_en    = 1'b0;
        par_store   = 1'b0;
        stop_chk    = 1'b0;
        stop_adv    = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (fall_pulse) begin
                    start_frame = 1'b1;
                    state_next  = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s == DP && sample_bit) begin
                        state_next = IDLE;
                    end else if (s == S_LAST) begin
                        s_clr      = 1'b1;
                        n_clr      = 1'b1;
                        state_next = DATA;
                    end else begin
                        s_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = (s == DP);
                    if (s == S_LAST) begin
                        s_clr = 1'b1;
                        if (n == N_LAST) begin
                            state_next = cfg_parity ? PARITY : STOP;
                        end else begin
                            n_inc = 1'b1;
                        end
                    end else begin
                        s_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    par_store = (s == DP);
                    if (s == S_LAST) begin
                        s_clr      = 1'b1;
                        state_next = STOP;
                    end else begin
                        s_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                // Finishing at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (tick) begin
                    if (s == DP) begin
                        stop_chk = 1'b1;
                        if (!cfg_two || stop_idx) begin
                            finish     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    if (s == S_LAST) begin
                        s_clr    = 1'b1;
                        stop_adv = 1'b1;
                    end else begin
                        s_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s          <= '0;
            n          <= '0;
            sr         <= '0;
            cfg_parity <= 1'b0;
            cfg_two    <= 1'b0;
            par_bit    <= 1'b0;
            ferr_pend  <= 1'b0;
            stop_idx   <= 1'b0;
            d_out      <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= finish;
            if (start_frame) begin
                s          <= '0;
                cfg_parity <= parity;
                cfg_two    <= (stop_bits == STOP_TWO);
                ferr_pend  <= 1'b0;
                stop_idx   <= 1'b0;
            end else if (s_clr) begin
                s <= '0;
            end else if (s_inc) begin
                s <= s + 1'b1;
            end
            if (n_clr) begin
                n <= '0;
            end else if (n_inc) begin
                n <= n + 1'b1;
            end
            if (shift_en) begin
                sr <= {sample_bit, sr[BITS_PER_DATA-1:1]};
            end
            if (par_store) begin
                par_bit <= sample_bit;
            end
            if (stop_chk && !sample_bit) begin
                ferr_pend <= 1'b1;
            end
            if (stop_adv) begin
                stop_idx <= 1'b1;
            end
            if (finish) begin
                d_out      <= sr;
                parity_err <= cfg_parity & (par_bit ^ (^sr));
                frame_err  <= ferr_pend | ~sample_bit;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with randomized frames and a frame-level model
module tb_uart_rx;

    localparam int CPT     = 4;
    localparam int BIT_CLK = 16 * CPT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       parity = 1'b0;
    logic [1:0] stop_bits = 2'd1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;

    int tests = 0;
    int fails = 0;

    int         done_cnt = 0;
    int         wide_cnt = 0;
    logic       prev_done = 1'b0;
    logic [7:0] last_d = 8'h00;
    logic       last_pe = 1'b0;
    logic       last_fe = 1'b0;
    logic [7:0] exp_last_d = 8'h00;

    uart_rx #(.NUM_TICKS(16), .BITS_PER_DATA(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .rx_in      (rx_in),
        .parity     (parity),
        .stop_bits  (stop_bits),
        .d_out      (d_out),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % CPT;
            tick = (ph == 0);
        end
    end

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            last_d  = d_out;
            last_pe = parity_err;
            last_fe = frame_err;
        end
        if (rx_done && prev_done) wide_cnt++;
        prev_done = rx_done;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clk_wait(input int nclk);
        repeat (nclk) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns just after a clk edge on which tick was high.
    task automatic align_tick();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (tick !== 1'b1 && guard < 4 * CPT);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int nclk);
        rx_in = v;
        clk_wait(nclk);
    endtask

    task automatic drive_head(input logic [7:0] data, input bit par_en, input logic par_val,
                              input bit scramble);
        rx_in = 1'b0;
        clk_wait(8);
        if (scramble) begin
            parity    = 1'($urandom);
            stop_bits = 2'($urandom);
        end
        clk_wait(BIT_CLK - 8);
        for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLK);
        if (par_en) drive_bit(par_val, BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit par_en, input bit par_flip,
                              input bit two, input logic [1:0] stop_lvl, input bit align,
                              input bit scramble);
        int sel;
        sel       = $urandom_range(0, 2);
        parity    = par_en;
        stop_bits = two ? 2'd2 : (sel == 0 ? 2'd0 : (sel == 1 ? 2'd1 : 2'd3));
        if (align) align_tick();
        drive_head(data, par_en, (^data) ^ par_flip, scramble);
        drive_bit(stop_lvl[0], BIT_CLK);
        if (two) drive_bit(stop_lvl[1], BIT_CLK);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clk_wait(5);
        tests++;
        if ({d_out, rx_done, parity_err, frame_err} !== 11'd0) begin
            fails++;
            $display("FAIL reset_in: got d=%h done=%b pe=%b fe=%b want all 0", d_out, rx_done, parity_err, frame_err);
        end
        reset = 1'b1;
        clk_wait(20);
        tests++;
        if ({d_out, parity_err, frame_err} !== 10'd0 || done_cnt != 0) begin
            fails++;
            $display("FAIL reset_out: got d=%h pe=%b fe=%b dones=%0d want 0", d_out, parity_err, frame_err, done_cnt);
        end
    endtask

    task automatic test_basic();
        int c0;
        c0 = done_cnt;
        send_frame(8'hA5, 0, 0, 0, 2'b11, 1, 0);
        clk_wait(8);
        exp_last_d = 8'hA5;
        tests++;
        if (done_cnt != c0 + 1) begin
            fails++;
            $display("FAIL basic_count: got %0d dones want 1", done_cnt - c0);
        end
        tests++;
        if ({last_d, last_pe, last_fe} !== {8'hA5, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_data: got d=%h pe=%b fe=%b want d=a5 pe=0 fe=0", last_d, last_pe, last_fe);
        end
    endtask

    task automatic test_parity();
        int c0;
        c0 = done_cnt;
        send_frame(8'h3C, 1, 0, 0, 2'b11, 1, 0);
        clk_wait(8);
        tests++;
        if (done_cnt != c0 + 1 || {last_d, last_pe, last_fe} !== {8'h3C, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL parity_ok: got n=%0d d=%h pe=%b fe=%b want n=1 d=3c pe=0 fe=0", done_cnt - c0, last_d, last_pe, last_fe);
        end
        send_frame(8'h3C, 1, 1, 0, 2'b11, 1, 0);
        exp_last_d = 8'h3C;
        clk_wait(100);
        tests++;
        if (done_cnt != c0 + 2 || {last_d, last_pe, last_fe} !== {8'h3C, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL parity_bad: got n=%0d d=%h pe=%b fe=%b want n=2 d=3c pe=1 fe=0", done_cnt - c0, last_d, last_pe, last_fe);
        end
        tests++;
        if (parity_err !== 1'b1) begin
            fails++;
            $display("FAIL parity_hold: got pe=%b want 1", parity_err);
        end
    endtask

    task automatic test_two_stop();
        int c0;
        c0 = done_cnt;
        parity    = 1'b0;
        stop_bits = 2'd2;
        align_tick();
        drive_head(8'h81, 0, 1'b0, 0);
        drive_bit(1'b1, BIT_CLK);
        tests++;
        if (done_cnt != c0) begin
            fails++;
            $display("FAIL two_stop_early: got %0d dones after first stop want 0", done_cnt - c0);
        end
        drive_bit(1'b0, BIT_CLK);
        rx_in = 1'b1;
        clk_wait(8);
        exp_last_d = 8'h81;
        tests++;
        if (done_cnt != c0 + 1 || {last_d, last_pe, last_fe} !== {8'h81, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL two_stop_frame: got n=%0d d=%h pe=%b fe=%b want n=1 d=81 pe=0 fe=1", done_cnt - c0, last_d, last_pe, last_fe);
        end
    endtask

    task automatic test_false_start();
        int c0;
        c0 = done_cnt;
        align_tick();
        drive_bit(1'b0, 4 * CPT);
        drive_bit(1'b1, 3 * BIT_CLK);
        tests++;
        if (done_cnt != c0 || d_out !== exp_last_d) begin
            fails++;
            $display("FAIL false_start: got n=%0d d=%h want n=0 d=%h", done_cnt - c0, d_out, exp_last_d);
        end
        send_frame(8'h96, 0, 0, 0, 2'b11, 1, 0);
        clk_wait(8);
        exp_last_d = 8'h96;
        tests++;
        if (done_cnt != c0 + 1 || last_d !== 8'h96) begin
            fails++;
            $display("FAIL false_start_recover: got n=%0d d=%h want n=1 d=96", done_cnt - c0, last_d);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        logic [7:0] junk;
        c0   = done_cnt;
        junk = 8'hF0;
        parity    = 1'b0;
        stop_bits = 2'd1;
        align_tick();
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 3; i++) drive_bit(junk[i], BIT_CLK);
        drive_bit(junk[3], BIT_CLK / 2);
        reset = 1'b0;
        clk_wait(5);
        rx_in = 1'b1;
        clk_wait(5);
        reset = 1'b1;
        clk_wait(2 * BIT_CLK);
        exp_last_d = 8'h00;
        tests++;
        if (done_cnt != c0 || d_out !== 8'h00 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_abort: got n=%0d d=%h pe=%b fe=%b want n=0 d=00 pe=0 fe=0", done_cnt - c0, d_out, parity_err, frame_err);
        end
        send_frame(8'h5A, 0, 0, 0, 2'b11, 1, 0);
        clk_wait(8);
        exp_last_d = 8'h5A;
        tests++;
        if (done_cnt != c0 + 1 || {last_d, last_pe, last_fe} !== {8'h5A, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_next: got n=%0d d=%h pe=%b fe=%b want n=1 d=5a", done_cnt - c0, last_d, last_pe, last_fe);
        end
    endtask

    // Glitch lands on the mid-bit sample of data bit 0 only; voting masks it.
    task automatic test_glitch();
        int c0;
        logic [7:0] want;
`ifdef UART_RX_MAJORITY_VOTE_EN
        want = 8'h01;
`else
        want = 8'h00;
`endif
        c0 = done_cnt;
        parity    = 1'b0;
        stop_bits = 2'd1;
        align_tick();
        drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b1, 7 * CPT);
        drive_bit(1'b0, CPT);
        drive_bit(1'b1, BIT_CLK - 8 * CPT);
        for (int i = 1; i < 8; i++) drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        clk_wait(8);
        exp_last_d = want;
        tests++;
        if (done_cnt != c0 + 1 || last_d !== want) begin
            fails++;
            $display("FAIL glitch: got n=%0d d=%h want n=1 d=%h", done_cnt - c0, last_d, want);
        end
    endtask

    task automatic test_random();
        logic [7:0] data;
        bit         par_en;
        bit         par_flip;
        bit         two;
        logic [1:0] lvl;
        bit         exp_fe;
        int         c0;
        for (int k = 0; k < 8; k++) begin
            data     = 8'($urandom);
            par_en   = 1'($urandom);
            par_flip = ($urandom_range(0, 2) == 0);
            two      = 1'($urandom);
            lvl[0]   = ($urandom_range(0, 3) != 0);
            lvl[1]   = ($urandom_range(0, 3) != 0);
            exp_fe   = two ? !(lvl[0] && lvl[1]) : !lvl[0];
            c0       = done_cnt;
            send_frame(data, par_en, par_flip, two, lvl, 1, 1);
            clk_wait(BIT_CLK);
            exp_last_d = data;
            tests++;
            if (done_cnt != c0 + 1 || {last_d, last_pe, last_fe} !== {data, par_en & par_flip, exp_fe}) begin
                fails++;
                $display("FAIL random_%0d: got n=%0d d=%h pe=%b fe=%b want n=1 d=%h pe=%b fe=%b",
                         k, done_cnt - c0, last_d, last_pe, last_fe, data, par_en & par_flip, exp_fe);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data;
        int         c0;
        c0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            data = 8'($urandom);
            send_frame(data, k[0], 0, 0, 2'b11, (k == 0), 0);
            tests++;
            if (done_cnt != c0 + k + 1 || {last_d, last_pe, last_fe} !== {data, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL back_to_back_%0d: got n=%0d d=%h pe=%b fe=%b want n=%0d d=%h",
                         k, done_cnt - c0, last_d, last_pe, last_fe, k + 1, data);
            end
            exp_last_d = data;
        end
        clk_wait(BIT_CLK);
    endtask

    task automatic test_pulse_width();
        tests++;
        if (wide_cnt != 0) begin
            fails++;
            $display("FAIL pulse_width: got %0d multi-cycle rx_done pulses want 0", wide_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_false_start();
        test_reset_mid();
        test_glitch();
        test_random();
        test_back_to_back();
        test_pulse_width();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
